// File: rtl/bomb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bomb_pkg : shared types for the bomb slot table and controller |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package bomb_pkg;

   typedef logic [7:0] coord_t;

   // Fuse field is sized for FUSE_TICKS up to 255
   localparam int FUSE_W_MAX = 8;

   localparam logic OWNER_P1 = 1'b0;
   localparam logic OWNER_P2 = 1'b1;

   typedef enum logic [2:0] {
      UP    = 3'd0,
      DOWN  = 3'd1,
      LEFT  = 3'd2,
      RIGHT = 3'd3,
      STOP  = 3'd4
   } dir_t;

   typedef struct packed {
      logic                  active;
      logic                  pending;
      logic                  owner;
      coord_t                coord;
      logic [FUSE_W_MAX-1:0] fuse;
   } bomb_slot_t;

endpackage
`default_nettype wire

// File: rtl/bomb_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bomb_prio_enc : lowest-index set-bit finder with found flag    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module bomb_prio_enc
   import bomb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bomb_tracker.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bomb_tracker : bomb slot table, fuse timing, explosion events  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module bomb_tracker
   import bomb_pkg::*;
#(
   parameter int SLOTS      = 8,
   parameter int FUSE_TICKS = 3,
   parameter int TICK_DIV   = 25000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         p1_set_bomb,
   input  logic [7:0]   p1_coordinate,
   input  logic         p2_set_bomb,
   input  logic [7:0]   p2_coordinate,
   input  logic         detonate_valid,
   input  logic [7:0]   detonate_coord,
   input  logic         explode_ready,
   output logic         explode_valid,
   output logic [7:0]   explode_coord,
   output logic         explode_owner,
   output logic [2:0]   bomb_num_1,
   output logic [2:0]   bomb_num_2,
   output logic [255:0] bomb_map,
   output logic         tick_o
);

   localparam int c_idx_w   = $clog2(SLOTS);
   localparam int c_presc_w = $clog2(TICK_DIV);
   localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(TICK_DIV - 1);
   localparam logic [FUSE_W_MAX-1:0] c_fuse_init = FUSE_W_MAX'(FUSE_TICKS);

   bomb_slot_t             r_slot     [SLOTS];
   bomb_slot_t             w_slot_nxt [SLOTS];
   logic [c_presc_w-1:0]   r_presc;
   logic                   w_tick;
   logic [SLOTS-1:0]       w_free, w_free_p2, w_pend;
   logic                   w_p1_found, w_p2_found, w_pend_found;
   logic [c_idx_w-1:0]     w_p1_idx, w_p2_idx, w_pend_idx;
   logic                   w_p1_dup, w_p2_dup, w_p1_ok, w_p2_ok, w_accept;
   logic                   r_valid, r_owner;
   coord_t                 r_coord;
   logic [c_idx_w-1:0]     r_sel;
   logic [2:0]             r_num1, r_num2, w_num1, w_num2;
   logic [255:0]           r_map, w_map;

   assign w_tick = (r_presc == c_presc_max);

   always_ff @(posedge clk) begin
      if (rst || w_tick) r_presc <= '0;
      else               r_presc <= r_presc + c_presc_w'(1);
   end

   always_comb begin
      w_free   = '0;
      w_p1_dup = 1'b0;
      w_p2_dup = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         w_free[i] = ~r_slot[i].active;
         if (r_slot[i].active && r_slot[i].coord == p1_coordinate) w_p1_dup = 1'b1;
         if (r_slot[i].active && r_slot[i].coord == p2_coordinate) w_p2_dup = 1'b1;
      end
   end

   assign w_p1_ok = p1_set_bomb & w_p1_found & ~w_p1_dup;

   // p2 allocates from the free set with p1's pick removed
   always_comb begin
      w_free_p2 = w_free;
      if (w_p1_ok) w_free_p2[w_p1_idx] = 1'b0;
   end

   assign w_p2_ok = p2_set_bomb & w_p2_found & ~w_p2_dup
                  & ~(w_p1_ok && (p1_coordinate == p2_coordinate));

   assign w_accept = r_valid & explode_ready;

   // The slot being drained this cycle must not be re-selected
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < SLOTS; i++) begin
         w_pend[i] = r_slot[i].active & r_slot[i].pending
                   & ~(w_accept && (r_sel == c_idx_w'(i)));
      end
   end

   bomb_prio_enc #(.WIDTH(SLOTS), .IDX_W(c_idx_w)) u_free_p1 (
      .req   (w_free),
      .found (w_p1_found),
      .idx   (w_p1_idx)
   );

   bomb_prio_enc #(.WIDTH(SLOTS), .IDX_W(c_idx_w)) u_free_p2 (
      .req   (w_free_p2),
      .found (w_p2_found),
      .idx   (w_p2_idx)
   );

   bomb_prio_enc #(.WIDTH(SLOTS), .IDX_W(c_idx_w)) u_pend (
      .req   (w_pend),
      .found (w_pend_found),
      .idx   (w_pend_idx)
   );

   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         w_slot_nxt[i] = r_slot[i];
         if (r_slot[i].active) begin
            if (r_slot[i].pending) begin
               if (w_accept && (r_sel == c_idx_w'(i))) w_slot_nxt[i] = '0;
            end else if (detonate_valid && (detonate_coord == r_slot[i].coord)) begin
               w_slot_nxt[i].pending = 1'b1;
            end else if (w_tick) begin
               if (r_slot[i].fuse == FUSE_W_MAX'(1)) w_slot_nxt[i].pending = 1'b1;
               else w_slot_nxt[i].fuse = r_slot[i].fuse - FUSE_W_MAX'(1);
            end
         end else if (w_p1_ok && (w_p1_idx == c_idx_w'(i))) begin
            w_slot_nxt[i] = '{active: 1'b1, pending: 1'b0, owner: OWNER_P1,
                              coord: p1_coordinate, fuse: c_fuse_init};
         end else if (w_p2_ok && (w_p2_idx == c_idx_w'(i))) begin
            w_slot_nxt[i] = '{active: 1'b1, pending: 1'b0, owner: OWNER_P2,
                              coord: p2_coordinate, fuse: c_fuse_init};
         end
      end
   end

   // Counts and map track the slot table as it will be after this edge
   always_comb begin
      w_num1 = '0;
      w_num2 = '0;
      w_map  = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (w_slot_nxt[i].active) begin
            w_map[w_slot_nxt[i].coord] = 1'b1;
            if (w_slot_nxt[i].owner == OWNER_P1) w_num1 = w_num1 + 3'd1;
            else                                 w_num2 = w_num2 + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
         r_valid <= 1'b0;
         r_coord <= '0;
         r_owner <= OWNER_P1;
         r_sel   <= '0;
         r_num1  <= '0;
         r_num2  <= '0;
         r_map   <= '0;
      end else begin
         for (int i = 0; i < SLOTS; i++) r_slot[i] <= w_slot_nxt[i];
         r_num1 <= w_num1;
         r_num2 <= w_num2;
         r_map  <= w_map;
         if (!(r_valid && !explode_ready)) begin
            r_valid <= w_pend_found;
            r_sel   <= w_pend_idx;
            r_coord <= w_pend_found ? r_slot[w_pend_idx].coord : '0;
            r_owner <= w_pend_found ? r_slot[w_pend_idx].owner : OWNER_P1;
         end
      end
   end

   assign explode_valid = r_valid;
   assign explode_coord = r_coord;
   assign explode_owner = r_owner;
   assign bomb_num_1    = r_num1;
   assign bomb_num_2    = r_num2;
   assign bomb_map      = r_map;
   assign tick_o        = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_bomb_tracker.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_bomb_tracker : scoreboard bench for bomb_tracker            |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_bomb_tracker;
   import bomb_pkg::*;

   localparam int SLOTS      = 8;
   localparam int FUSE_TICKS = 3;
   localparam int TICK_DIV   = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         p1_set_bomb = 1'b0, p2_set_bomb = 1'b0;
   logic [7:0]   p1_coordinate = '0, p2_coordinate = '0;
   logic         detonate_valid = 1'b0;
   logic [7:0]   detonate_coord = '0;
   logic         explode_ready = 1'b1;
   logic         explode_valid, explode_owner, tick_o;
   logic [7:0]   explode_coord;
   logic [2:0]   bomb_num_1, bomb_num_2;
   logic [255:0] bomb_map;

   int n_checks = 0;
   int n_pass   = 0;
   logic [8:0] sb_q [$];

   always #5 clk = ~clk;

   bomb_tracker #(.SLOTS(SLOTS), .FUSE_TICKS(FUSE_TICKS), .TICK_DIV(TICK_DIV)) dut (
      .clk            (clk),
      .rst            (rst),
      .p1_set_bomb    (p1_set_bomb),
      .p1_coordinate  (p1_coordinate),
      .p2_set_bomb    (p2_set_bomb),
      .p2_coordinate  (p2_coordinate),
      .detonate_valid (detonate_valid),
      .detonate_coord (detonate_coord),
      .explode_ready  (explode_ready),
      .explode_valid  (explode_valid),
      .explode_coord  (explode_coord),
      .explode_owner  (explode_owner),
      .bomb_num_1     (bomb_num_1),
      .bomb_num_2     (bomb_num_2),
      .bomb_map       (bomb_map),
      .tick_o         (tick_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic place(input logic s1, input coord_t c1, input logic s2, input coord_t c2);
      p1_set_bomb   = s1;
      p1_coordinate = c1;
      p2_set_bomb   = s2;
      p2_coordinate = c2;
      step();
      p1_set_bomb = 1'b0;
      p2_set_bomb = 1'b0;
   endtask

   task automatic wait_valid(input int max, output int ticks);
      int n = 0;
      ticks = 0;
      while (!explode_valid && n < max) begin
         if (tick_o) ticks++;
         step();
         n++;
      end
      if (!explode_valid) check("valid_timeout", {31'd0, explode_valid}, 32'd1);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((bomb_num_1 != 0 || bomb_num_2 != 0 || explode_valid) && n < max) begin
         step();
         n++;
      end
      check("drain_idle", {25'd0, bomb_num_1, bomb_num_2, explode_valid}, 32'd0);
   endtask

   // Each accepted event is compared against the oldest expected one
   always @(negedge clk) begin
      if (!rst && explode_valid && explode_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_event", 32'(sb_q.size()), 32'd1);
         end else begin
            logic [8:0] exp_evt;
            exp_evt = sb_q.pop_front();
            check("sb_event", {23'd0, explode_owner, explode_coord}, {23'd0, exp_evt});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ticks;
      int k;

      repeat (3) step();
      rst = 1'b0;
      check("rst_valid", {31'd0, explode_valid}, 32'd0);
      check("rst_coord", {24'd0, explode_coord}, 32'd0);
      check("rst_owner", {31'd0, explode_owner}, 32'd0);
      check("rst_nums", {26'd0, bomb_num_1, bomb_num_2}, 32'd0);
      check("rst_map", {31'd0, |bomb_map}, 32'd0);
      check("rst_tick", {31'd0, tick_o}, 32'd0);

      // single bomb: visibility, fuse length, release
      place(1'b1, 8'h11, 1'b0, 8'h00);
      sb_q.push_back({OWNER_P1, 8'h11});
      check("t1_num1", 32'(bomb_num_1), 32'd1);
      check("t1_map", {31'd0, bomb_map[8'h11]}, 32'd1);
      wait_valid(40, ticks);
      check("t1_fuse_ticks", 32'(ticks), 32'(FUSE_TICKS));
      check("t1_coord", {24'd0, explode_coord}, 32'h11);
      step();
      check("t1_freed_valid", {31'd0, explode_valid}, 32'd0);
      check("t1_freed_num1", 32'(bomb_num_1), 32'd0);
      check("t1_freed_map", {31'd0, bomb_map[8'h11]}, 32'd0);

      // same coord, same cycle: p1 only
      place(1'b1, 8'h22, 1'b1, 8'h22);
      sb_q.push_back({OWNER_P1, 8'h22});
      check("t2_num1", 32'(bomb_num_1), 32'd1);
      check("t2_num2", 32'(bomb_num_2), 32'd0);
      wait_idle(60);

      // table full, ninth request rejected
      for (int i = 0; i < 4; i++) begin
         place(1'b1, coord_t'(i), 1'b1, coord_t'(8'h10 + i));
         sb_q.push_back({OWNER_P1, coord_t'(i)});
         sb_q.push_back({OWNER_P2, coord_t'(8'h10 + i)});
      end
      place(1'b1, 8'h40, 1'b0, 8'h00);
      check("t3_num1", 32'(bomb_num_1), 32'd4);
      check("t3_num2", 32'(bomb_num_2), 32'd4);
      check("t3_map_rejected", {31'd0, bomb_map[8'h40]}, 32'd0);
      check("t3_map_held", {31'd0, bomb_map[8'h13]}, 32'd1);
      wait_idle(100);

      // two bombs expiring together, backpressure then drain
      explode_ready = 1'b0;
      place(1'b1, 8'h50, 1'b1, 8'h51);
      sb_q.push_back({OWNER_P1, 8'h50});
      sb_q.push_back({OWNER_P2, 8'h51});
      wait_valid(40, ticks);
      check("t4_first", {23'd0, explode_owner, explode_coord}, {23'd0, OWNER_P1, 8'h50});
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4_hold", {22'd0, explode_valid, explode_owner, explode_coord},
               {22'd0, 1'b1, OWNER_P1, 8'h50});
      end
      explode_ready = 1'b1;
      step();
      check("t4_second", {22'd0, explode_valid, explode_owner, explode_coord},
            {22'd0, 1'b1, OWNER_P2, 8'h51});
      step();
      check("t4_drained", {31'd0, explode_valid}, 32'd0);
      wait_idle(20);

      // chain reaction: miss then hit
      place(1'b1, 8'h33, 1'b0, 8'h00);
      detonate_valid = 1'b1;
      detonate_coord = 8'h77;
      step();
      detonate_valid = 1'b0;
      check("t5_miss_a", {31'd0, explode_valid}, 32'd0);
      step();
      check("t5_miss_b", {31'd0, explode_valid}, 32'd0);
      check("t5_miss_num1", 32'(bomb_num_1), 32'd1);
      sb_q.push_back({OWNER_P1, 8'h33});
      detonate_valid = 1'b1;
      detonate_coord = 8'h33;
      step();
      detonate_valid = 1'b0;
      check("t5_hit_lat1", {31'd0, explode_valid}, 32'd0);
      step();
      check("t5_hit", {23'd0, explode_valid, explode_coord}, {23'd0, 1'b1, 8'h33});
      wait_idle(20);

      // reset with three armed and one pending
      explode_ready = 1'b0;
      place(1'b1, 8'h60, 1'b0, 8'h00);
      wait_valid(40, ticks);
      place(1'b1, 8'h61, 1'b1, 8'h62);
      place(1'b1, 8'h63, 1'b0, 8'h00);
      check("t6_num1", 32'(bomb_num_1), 32'd3);
      check("t6_num2", 32'(bomb_num_2), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      explode_ready = 1'b1;
      check("t6_valid", {31'd0, explode_valid}, 32'd0);
      check("t6_coord", {24'd0, explode_coord}, 32'd0);
      check("t6_nums", {26'd0, bomb_num_1, bomb_num_2}, 32'd0);
      check("t6_map", {31'd0, |bomb_map}, 32'd0);
      check("t6_tick", {31'd0, tick_o}, 32'd0);
      k = 0;
      while (!tick_o && k < 10) begin
         step();
         k++;
      end
      check("t6_presc_restart", 32'(k), 32'(TICK_DIV - 1));
      repeat (20) step();
      check("t6_no_event", {31'd0, explode_valid}, 32'd0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
